// File: rtl/rf_write_scheduler.sv
// Write-port sequencer for the core register file: zeroing sweep after reset or
// on request, then round-robin arbitration of two writeback requesters.
module rf_write_scheduler #(
  parameter int ADDR_W        = 6,
  parameter int DATA_W        = 32,
  parameter int INIT_ENABLE   = 1,
  parameter int ZERO_REG_DROP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_req,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_wr,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_d,
  output logic              init_done
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t            RESET_STATE = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
  localparam logic [ADDR_W-1:0] CNT_LAST    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO   = {ADDR_W{1'b0}};
  localparam logic              DROP_ZERO   = (ZERO_REG_DROP != 0);

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   cnt_r, cnt_nxt_s;
  logic                last_r, last_nxt_s;
  logic                grant0_s, grant1_s;
  logic                wr_nxt_s;
  logic [ADDR_W-1:0]   wa_nxt_s;
  logic [DATA_W-1:0]   d_nxt_s;

  // Next-state, arbitration and write-port selection
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    last_nxt_s  = last_r;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    wr_nxt_s    = 1'b0;
    wa_nxt_s    = rf_wa;
    d_nxt_s     = rf_d;
    case (state_r)
      ST_INIT: begin
        wr_nxt_s = 1'b1;
        wa_nxt_s = cnt_r;
        d_nxt_s  = {DATA_W{1'b0}};
        // init_req is deliberately ignored here so a sweep never restarts itself
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = {ADDR_W{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        // Under contention the requester that did not win last time goes first
        if (req0_valid && (!req1_valid || last_r)) begin
          grant0_s   = 1'b1;
          wa_nxt_s   = req0_addr;
          d_nxt_s    = req0_data;
          wr_nxt_s   = !(DROP_ZERO && (req0_addr == ADDR_ZERO));
          last_nxt_s = 1'b0;
        end else if (req1_valid) begin
          grant1_s   = 1'b1;
          wa_nxt_s   = req1_addr;
          d_nxt_s    = req1_data;
          wr_nxt_s   = !(DROP_ZERO && (req1_addr == ADDR_ZERO));
          last_nxt_s = 1'b1;
        end else begin
          wr_nxt_s = 1'b0;
        end
        if (init_req) begin
          state_nxt_s = ST_INIT;
          cnt_nxt_s   = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = RESET_STATE;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, sweep counter, pointer and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RESET_STATE;
      cnt_r   <= {ADDR_W{1'b0}};
      last_r  <= 1'b1;
      rf_wr   <= 1'b0;
      rf_wa   <= {ADDR_W{1'b0}};
      rf_d    <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      last_r  <= last_nxt_s;
      rf_wr   <= wr_nxt_s;
      rf_wa   <= wa_nxt_s;
      rf_d    <= d_nxt_s;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign init_done  = (state_r == ST_RUN);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: sweep, arbitration, zero-register drop,
// init_req handling and asynchronous reset.
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        init_req = 1'b0;
  logic        req0_valid = 1'b0;
  logic [5:0]  req0_addr = 6'd0;
  logic [31:0] req0_data = 32'd0;
  logic        req1_valid = 1'b0;
  logic [5:0]  req1_addr = 6'd0;
  logic [31:0] req1_data = 32'd0;

  logic        d0_req0_ready, d0_req1_ready, d0_rf_wr, d0_init_done;
  logic [5:0]  d0_rf_wa;
  logic [31:0] d0_rf_d;
  logic        d1_req0_ready, d1_req1_ready, d1_rf_wr, d1_init_done;
  logic [5:0]  d1_rf_wa;
  logic [31:0] d1_rf_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rf_write_scheduler #(.ADDR_W(6), .DATA_W(32), .INIT_ENABLE(1), .ZERO_REG_DROP(1)) dut0 (
    .clk(clk), .reset(reset), .init_req(init_req),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(d0_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(d0_req1_ready),
    .rf_wr(d0_rf_wr), .rf_wa(d0_rf_wa), .rf_d(d0_rf_d), .init_done(d0_init_done)
  );

  rf_write_scheduler #(.ADDR_W(6), .DATA_W(32), .INIT_ENABLE(0), .ZERO_REG_DROP(0)) dut1 (
    .clk(clk), .reset(reset), .init_req(init_req),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(d1_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(d1_req1_ready),
    .rf_wr(d1_rf_wr), .rf_wa(d1_rf_wa), .rf_d(d1_rf_d), .init_done(d1_init_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks one sweep write of dut0 already visible on the port
  task automatic check_sweep(input int i);
    check_eq("sweep_wr", 64'(d0_rf_wr), 64'd1);
    check_eq("sweep_wa", 64'(d0_rf_wa), 64'(i));
    check_eq("sweep_d", 64'(d0_rf_d), 64'd0);
    check_eq("sweep_rdy0", 64'(d0_req0_ready), 64'd0);
    check_eq("sweep_rdy1", 64'(d0_req1_ready), 64'd0);
    check_eq("sweep_done", 64'(d0_init_done), 64'(i == 63));
  endtask

  initial begin
    // Reset values
    #2 reset = 1'b1;
    #1;
    check_eq("rst_wr", 64'(d0_rf_wr), 64'd0);
    check_eq("rst_wa", 64'(d0_rf_wa), 64'd0);
    check_eq("rst_d", 64'(d0_rf_d), 64'd0);
    check_eq("rst_done0", 64'(d0_init_done), 64'd0);
    check_eq("rst_done1", 64'(d1_init_done), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Sweep after reset; a pending request must not be granted during INIT
    req0_valid = 1'b1;
    req0_addr  = 6'd9;
    req0_data  = 32'h99;
    for (int i = 0; i < 64; i++) begin
      tick();
      check_sweep(i);
      if (i == 62) req0_valid = 1'b0;
    end

    // Continuous contention: first goes to req0, then alternates
    req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("rr_rdy0", 64'(d0_req0_ready), 64'((k % 2) == 0));
      check_eq("rr_rdy1", 64'(d0_req1_ready), 64'((k % 2) == 1));
      tick();
      check_eq("rr_wr", 64'(d0_rf_wr), 64'd1);
      check_eq("rr_wa", 64'(d0_rf_wa), ((k % 2) == 0) ? 64'd1 : 64'd2);
      check_eq("rr_d", 64'(d0_rf_d), ((k % 2) == 0) ? 64'h11 : 64'h22);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check_eq("idle_wr", 64'(d0_rf_wr), 64'd0);
    check_eq("idle_wa_hold", 64'(d0_rf_wa), 64'd2);
    check_eq("idle_d_hold", 64'(d0_rf_d), 64'h22);

    // Single requester 0
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 32'hDEADBEEF;
    #1;
    check_eq("r0_rdy", 64'(d0_req0_ready), 64'd1);
    check_eq("r0_rdy1", 64'(d0_req1_ready), 64'd0);
    tick();
    check_eq("r0_wr", 64'(d0_rf_wr), 64'd1);
    check_eq("r0_wa", 64'(d0_rf_wa), 64'd5);
    check_eq("r0_d", 64'(d0_rf_d), 64'hDEADBEEF);
    req0_valid = 1'b0;
    tick();
    check_eq("r0_wr_after", 64'(d0_rf_wr), 64'd0);
    check_eq("r0_wa_hold", 64'(d0_rf_wa), 64'd5);

    // Write to register 0: dropped on dut0, written on dut1
    req1_valid = 1'b1; req1_addr = 6'd0; req1_data = 32'h55;
    #1;
    check_eq("z_rdy_d0", 64'(d0_req1_ready), 64'd1);
    check_eq("z_rdy_d1", 64'(d1_req1_ready), 64'd1);
    tick();
    req1_valid = 1'b0;
    check_eq("z_wr_drop", 64'(d0_rf_wr), 64'd0);
    check_eq("z_wr_keep", 64'(d1_rf_wr), 64'd1);
    check_eq("z_wa_keep", 64'(d1_rf_wa), 64'd0);
    check_eq("z_d_keep", 64'(d1_rf_d), 64'h55);

    // init_req together with a grant: write issues, then a fresh sweep
    req0_valid = 1'b1; req0_addr = 6'd7; req0_data = 32'h77;
    init_req = 1'b1;
    #1;
    check_eq("ir_rdy", 64'(d0_req0_ready), 64'd1);
    tick();
    req0_valid = 1'b0;
    init_req = 1'b0;
    check_eq("ir_wr", 64'(d0_rf_wr), 64'd1);
    check_eq("ir_wa", 64'(d0_rf_wa), 64'd7);
    check_eq("ir_d", 64'(d0_rf_d), 64'h77);
    check_eq("ir_done", 64'(d0_init_done), 64'd0);
    for (int i = 0; i < 64; i++) begin
      tick();
      check_sweep(i);
      if (i == 20) init_req = 1'b1;
      else init_req = 1'b0;
    end

    // Reset asserted mid-sweep, then the sweep restarts from 0
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i <= 30; i++) begin
      tick();
      check_sweep(i);
    end
    reset = 1'b1;
    #1;
    check_eq("mr_wr", 64'(d0_rf_wr), 64'd0);
    check_eq("mr_wa", 64'(d0_rf_wa), 64'd0);
    check_eq("mr_d", 64'(d0_rf_d), 64'd0);
    check_eq("mr_done", 64'(d0_init_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_sweep(i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
